// File: rtl/sum_accum_pkg.sv
// Shared width configuration for the adder result stream and its consumers.
// The adder and sum_accum both derive their widths from here so they stay in step.
package sum_accum_pkg;

   localparam int CFG_DATA_W  = 8;
   localparam int CFG_IN_W    = CFG_DATA_W + 1;
   localparam int CFG_ACC_LEN = 16;

   // Total width needed to add acc_len values of in_w bits without wrapping.
   function automatic int acc_w(input int in_w, input int acc_len);
      return in_w + $clog2(acc_len);
   endfunction

   // Width needed to hold a sample count from 0 up to and including acc_len.
   function automatic int cnt_w(input int acc_len);
      return $clog2(acc_len + 1);
   endfunction

endpackage

// File: rtl/sum_accum.sv
// sum_accum: accumulates ACC_LEN consecutive adder sums into one wide total and
// emits total plus sample count on a registered valid/ready output. A flush pulse
// closes a partial window early; a flush seen while stalled is held until the
// output can take a new emission.
module sum_accum
   import sum_accum_pkg::*;
#(
   parameter  int IN_W    = CFG_IN_W,
   parameter  int ACC_LEN = CFG_ACC_LEN,
   localparam int ACC_W   = acc_w(IN_W, ACC_LEN),
   localparam int CNT_W   = cnt_w(ACC_LEN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             flush,
   output logic [ACC_W-1:0] m_data,
   output logic [CNT_W-1:0] m_cnt,
   output logic             m_valid,
   input  logic             m_ready
);

   // Window registers
   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] cnt_r;
   // Flush request that arrived while the output was stalled
   logic             flush_pend_r;

   logic             accept_s;
   logic             last_s;
   logic             flush_req_s;
   logic             flush_go_s;
   logic             emit_s;
   logic [ACC_W-1:0] base_s;
   logic [ACC_W-1:0] total_s;
   logic [CNT_W-1:0] cnt_inc_s;

   // The output register is the only buffer: a new sample may enter whenever it is
   // empty or being drained this cycle.
   assign s_ready = !m_valid || m_ready;

   // Window arithmetic and emission decision for the current cycle.
   always_comb begin
      accept_s = s_valid && s_ready;
      // A fresh window starts from zero rather than the stale acc_r contents.
      if (cnt_r == {CNT_W{1'b0}}) begin
         base_s = {ACC_W{1'b0}};
      end else begin
         base_s = acc_r;
      end
      if (accept_s) begin
         total_s   = base_s + ACC_W'(s_data);
         cnt_inc_s = cnt_r + CNT_W'(1);
      end else begin
         total_s   = base_s;
         cnt_inc_s = cnt_r;
      end
      last_s      = accept_s && (cnt_r == CNT_W'(ACC_LEN - 1));
      flush_req_s = flush || flush_pend_r;
      // A flush coinciding with the completing sample is just the normal emission.
      flush_go_s  = flush_req_s && s_ready && (cnt_inc_s != {CNT_W{1'b0}}) && !last_s;
      emit_s      = last_s || flush_go_s;
   end

   // Window group: running sum and sample count.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= {ACC_W{1'b0}};
         cnt_r <= {CNT_W{1'b0}};
      end else if (emit_s) begin
         acc_r <= total_s;
         cnt_r <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         acc_r <= total_s;
         cnt_r <= cnt_inc_s;
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end

   // Output group: load on emission, otherwise hold until drained.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_data  <= {ACC_W{1'b0}};
         m_cnt   <= {CNT_W{1'b0}};
         m_valid <= 1'b0;
      end else if (emit_s) begin
         m_data  <= total_s;
         m_cnt   <= cnt_inc_s;
         m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
         m_valid <= 1'b0;
      end else begin
         m_valid <= m_valid;
      end
   end

   // Pending flush: remembered while stalled, consumed on the first cycle the
   // output can accept (executed, absorbed by a full emission, or dropped if empty).
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_pend_r <= 1'b0;
      end else if (flush_req_s && !s_ready) begin
         flush_pend_r <= 1'b1;
      end else if (flush_req_s) begin
         flush_pend_r <= 1'b0;
      end else begin
         flush_pend_r <= flush_pend_r;
      end
   end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum with IN_W=9, ACC_LEN=4 (ACC_W=11).
module tb_sum_accum;

   localparam int IN_W    = 9;
   localparam int ACC_LEN = 4;
   localparam int ACC_W   = 11;
   localparam int CNT_W   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic [IN_W-1:0]  s_data;
   logic             s_valid;
   logic             s_ready;
   logic             flush;
   logic [ACC_W-1:0] m_data;
   logic [CNT_W-1:0] m_cnt;
   logic             m_valid;
   logic             m_ready;

   int n_checks = 0;
   int n_fail   = 0;

   sum_accum #(.IN_W(IN_W), .ACC_LEN(ACC_LEN)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .flush   (flush),
      .m_data  (m_data),
      .m_cnt   (m_cnt),
      .m_valid (m_valid),
      .m_ready (m_ready)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs change and outputs are read here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for exactly one cycle.
   task automatic send(input logic [IN_W-1:0] d);
      s_data  = d;
      s_valid = 1'b1;
      step();
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; flush = 1'b0; m_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
      n_checks++; if (m_data !== 11'd0) begin n_fail++; $display("FAIL reset_m_data got %0d want 0", m_data); end
      n_checks++; if (m_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_m_cnt got %0d want 0", m_cnt); end
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
   endtask

   task automatic test_basic();
      m_ready = 1'b1;
      send(9'd1); send(9'd2); send(9'd3);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", m_valid); end
      send(9'd4);
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b want 1", m_valid); end
      n_checks++; if (m_data !== 11'd10) begin n_fail++; $display("FAIL basic_data got %0d want 10", m_data); end
      n_checks++; if (m_cnt !== 3'd4) begin n_fail++; $display("FAIL basic_cnt got %0d want 4", m_cnt); end
      step();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got %b want 0", m_valid); end
   endtask

   task automatic test_max_value();
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(9'd511);
      n_checks++; if (m_data !== 11'd2044) begin n_fail++; $display("FAIL max_data got %0d want 2044", m_data); end
      n_checks++; if (m_cnt !== 3'd4) begin n_fail++; $display("FAIL max_cnt got %0d want 4", m_cnt); end
      for (int i = 0; i < 4; i++) send(9'd1);
      n_checks++; if (m_data !== 11'd4) begin n_fail++; $display("FAIL max_next_data got %0d want 4", m_data); end
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL max_next_valid got %b want 1", m_valid); end
      step();
   endtask

   task automatic test_back_to_back();
      int bad;
      m_ready = 1'b1;
      send(9'd1); send(9'd2); send(9'd3); send(9'd4);
      m_ready = 1'b0;
      s_data = 9'd7; s_valid = 1'b1;
      #1;
      n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL bp_s_ready got %b want 0", s_ready); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (m_valid !== 1'b1 || m_data !== 11'd10 || m_cnt !== 3'd4) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold got %0d unstable cycles want 0", bad); end
      m_ready = 1'b1;
      #1;
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", s_ready); end
      step();
      s_valid = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", m_valid); end
      // 7 was taken in the drain cycle; three more ones complete that window.
      send(9'd1); send(9'd1); send(9'd1);
      n_checks++; if (m_data !== 11'd10) begin n_fail++; $display("FAIL bp_window_data got %0d want 10", m_data); end
      n_checks++; if (m_cnt !== 3'd4) begin n_fail++; $display("FAIL bp_window_cnt got %0d want 4", m_cnt); end
      step();
   endtask

   task automatic test_flush();
      m_ready = 1'b1;
      send(9'd5); send(9'd6);
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b want 1", m_valid); end
      n_checks++; if (m_data !== 11'd11) begin n_fail++; $display("FAIL flush_data got %0d want 11", m_data); end
      n_checks++; if (m_cnt !== 3'd2) begin n_fail++; $display("FAIL flush_cnt got %0d want 2", m_cnt); end
      step();
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b want 0", m_valid); end
      send(9'd1); send(9'd2);
      s_data = 9'd7; s_valid = 1'b1; flush = 1'b1;
      step();
      s_valid = 1'b0; flush = 1'b0;
      n_checks++; if (m_data !== 11'd10) begin n_fail++; $display("FAIL flush_accept_data got %0d want 10", m_data); end
      n_checks++; if (m_cnt !== 3'd3) begin n_fail++; $display("FAIL flush_accept_cnt got %0d want 3", m_cnt); end
      step();
   endtask

   // While the output holds data no sample can enter, so the window is empty when
   // the stall flush arrives; the sample accepted on release forms the flushed window.
   task automatic test_flush_stalled();
      m_ready = 1'b1;
      send(9'd1); send(9'd2); send(9'd3); send(9'd4);
      m_ready = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;
      n_checks++; if (m_valid !== 1'b1 || m_data !== 11'd10) begin n_fail++; $display("FAIL stall_hold got %b/%0d want 1/10", m_valid, m_data); end
      step();
      m_ready = 1'b1; s_data = 9'd8; s_valid = 1'b1;
      step();
      s_valid = 1'b0;
      n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL stall_emit_valid got %b want 1", m_valid); end
      n_checks++; if (m_data !== 11'd8) begin n_fail++; $display("FAIL stall_emit_data got %0d want 8", m_data); end
      n_checks++; if (m_cnt !== 3'd1) begin n_fail++; $display("FAIL stall_emit_cnt got %0d want 1", m_cnt); end
      step();
      // Pending flush released with nothing accepted must be dropped.
      send(9'd1); send(9'd2); send(9'd3); send(9'd4);
      m_ready = 1'b0;
      flush = 1'b1; step(); flush = 1'b0;
      m_ready = 1'b1;
      step();
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %b want 0", m_valid); end
      send(9'd1);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_stale_flush got %b want 0", m_valid); end
      send(9'd2); send(9'd3); send(9'd4);
      n_checks++; if (m_data !== 11'd10 || m_cnt !== 3'd4) begin n_fail++; $display("FAIL stall_after got %0d/%0d want 10/4", m_data, m_cnt); end
      step();
   endtask

   task automatic test_mid_reset();
      m_ready = 1'b1;
      send(9'd9); send(9'd9);
      rst = 1'b1; step(); rst = 1'b0;
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", m_valid); end
      send(9'd1); send(9'd2); send(9'd3);
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard got %b want 0", m_valid); end
      send(9'd4);
      n_checks++; if (m_data !== 11'd10) begin n_fail++; $display("FAIL rst_data got %0d want 10", m_data); end
      n_checks++; if (m_cnt !== 3'd4) begin n_fail++; $display("FAIL rst_cnt got %0d want 4", m_cnt); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_value();
      test_back_to_back();
      test_flush();
      test_flush_stalled();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
